// File: rtl/alu_pkg.sv
// Opcode encodings and per-opcode flag/legality decode shared by the ALU result stage.
package alu_pkg;

  localparam int unsigned OP_W = 4;
  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_ADD  = 4'd0;
  localparam opcode_t OP_SUB  = 4'd1;
  localparam opcode_t OP_AND  = 4'd2;
  localparam opcode_t OP_OR   = 4'd3;
  localparam opcode_t OP_XOR  = 4'd4;
  localparam opcode_t OP_NOR  = 4'd5;
  localparam opcode_t OP_SLT  = 4'd6;
  localparam opcode_t OP_SLTU = 4'd7;
  localparam opcode_t OP_SHL  = 4'd8;
  localparam opcode_t OP_SHR  = 4'd9;
  localparam opcode_t OP_MUL  = 4'd10;

  function automatic logic updates_z(input opcode_t op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU, OP_MUL};
  endfunction

  function automatic logic updates_c(input opcode_t op);
    return op inside {OP_ADD, OP_SUB, OP_SHL, OP_SHR};
  endfunction

  function automatic logic is_illegal(input opcode_t op);
    return op > OP_MUL;
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Decode/ALU-facing input, writeback output, flag and forwarding signals of the result stage.
interface alu_result_stage_if
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  opcode_t           in_opcode;
  logic [REG_AW-1:0] in_rd;
  logic              in_wr_en;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_carry;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [REG_AW-1:0] out_rd;
  logic              out_wr_en;
  logic              flag_z;
  logic              flag_c;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_rd;
  logic [DATA_W-1:0] fwd_data;
  logic              illegal_op;
  logic              clr_illegal;

  modport slave (
    input  in_valid, in_opcode, in_rd, in_wr_en, alu_result, alu_zero, alu_carry,
    input  out_ready, clr_illegal,
    output in_ready, out_valid, out_result, out_rd, out_wr_en, flag_z, flag_c,
    output fwd_valid, fwd_rd, fwd_data, illegal_op
  );

  modport master (
    output in_valid, in_opcode, in_rd, in_wr_en, alu_result, alu_zero, alu_carry,
    output out_ready, clr_illegal,
    input  in_ready, out_valid, out_result, out_rd, out_wr_en, flag_z, flag_c,
    input  fwd_valid, fwd_rd, fwd_data, illegal_op
  );
endinterface

// File: rtl/skid_buffer.sv
// Two-entry valid/ready register (main + skid) with a registered in_ready; strict FIFO order.
module skid_buffer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept, drain;

  assign accept = in_valid & ~skid_valid_q;
  assign drain  = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (skid_valid_q) begin
      // Skid full: no accept this cycle; a drain promotes the skid entry.
      if (drain) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q || drain) begin
        main_d       = in_data;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = in_data;
        skid_valid_d = 1'b1;
      end
    end else if (drain) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/alu_result_stage.sv
// Execute/writeback boundary: registers ALU results, keeps architectural flags, flags illegal
// opcodes and forwards the pending main entry to decode.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input logic               clk,
  input logic               rst_n,
  alu_result_stage_if.slave bus
);

  localparam int unsigned EntryW = DATA_W + REG_AW + 1;

  logic              accept;
  logic              illegal;
  logic [EntryW-1:0] in_entry;
  logic [EntryW-1:0] out_entry;
  logic              flag_z_q, flag_c_q, illegal_q;

  assign accept  = bus.in_valid & bus.in_ready;
  assign illegal = is_illegal(bus.in_opcode);

  // Illegal ops still flow down the pipe but can never write a register.
  assign in_entry = illegal ? {{DATA_W{1'b0}}, bus.in_rd, 1'b0}
                            : {bus.alu_result, bus.in_rd, bus.in_wr_en};

  skid_buffer #(
    .W (EntryW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_entry),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_entry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (accept && updates_z(bus.in_opcode)) flag_z_q <= bus.alu_zero;
      if (accept && updates_c(bus.in_opcode)) flag_c_q <= bus.alu_carry;
      // A new illegal accept takes priority over a simultaneous clear.
      if (accept && illegal)    illegal_q <= 1'b1;
      else if (bus.clr_illegal) illegal_q <= 1'b0;
    end
  end

  assign {bus.out_result, bus.out_rd, bus.out_wr_en} = out_entry;

  assign bus.flag_z     = flag_z_q;
  assign bus.flag_c     = flag_c_q;
  assign bus.illegal_op = illegal_q;
  assign bus.fwd_valid  = bus.out_valid & bus.out_wr_en;
  assign bus.fwd_rd     = bus.out_rd;
  assign bus.fwd_data   = bus.out_result;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed ops push expected entries, a monitor pops them.
module tb_alu_result_stage;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_result_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

  alu_result_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_pop = 0;
  logic m_z = 1'b0, m_c = 1'b0, m_ill = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check32(name, {31'b0, act}, {31'b0, exp});
  endtask

  function automatic logic m_upd_z(input opcode_t op);
    return (op <= 4'd7) || (op == 4'd10);
  endfunction

  function automatic logic m_upd_c(input opcode_t op);
    return (op == 4'd0) || (op == 4'd1) || (op == 4'd8) || (op == 4'd9);
  endfunction

  // Drives one op and holds it until accepted; returns with inputs still applied, 1ns past the
  // accepting edge.
  task automatic issue(input opcode_t op, input logic [31:0] res, input logic z, input logic c,
                       input logic [4:0] rd, input logic wr, input logic clr, output int waited);
    exp_t e;
    bus.in_valid    = 1'b1;
    bus.in_opcode   = op;
    bus.alu_result  = res;
    bus.alu_zero    = z;
    bus.alu_carry   = c;
    bus.in_rd       = rd;
    bus.in_wr_en    = wr;
    bus.clr_illegal = clr;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      check1("accept_timeout", bus.in_ready, 1'b1);
    end else begin
      if (op > 4'd10) begin
        e.res = 32'h0; e.rd = rd; e.wr = 1'b0;
        m_ill = 1'b1;
      end else begin
        e.res = res; e.rd = rd; e.wr = wr;
        if (clr) m_ill = 1'b0;
      end
      if (m_upd_z(op)) m_z = z;
      if (m_upd_c(op)) m_c = c;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.clr_illegal = 1'b0;
    check1("flag_z_model", bus.flag_z, m_z);
    check1("flag_c_model", bus.flag_c, m_c);
    check1("illegal_model", bus.illegal_op, m_ill);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check1("unexpected_output", bus.out_valid, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_pop++;
        check32("out_result", bus.out_result, e.res);
        check32("out_rd", 32'(bus.out_rd), 32'(e.rd));
        check1("out_wr_en", bus.out_wr_en, e.wr);
        check32("fwd_data", bus.fwd_data, e.res);
        check32("fwd_rd", 32'(bus.fwd_rd), 32'(e.rd));
        check1("fwd_valid", bus.fwd_valid, e.wr);
      end
    end
  end

  initial begin
    int w;
    int pops0;
    bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_rd = '0; bus.in_wr_en = 1'b0;
    bus.alu_result = '0; bus.alu_zero = 1'b0; bus.alu_carry = 1'b0;
    bus.out_ready = 1'b0; bus.clr_illegal = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check1("rst_out_valid", bus.out_valid, 1'b0);
    check1("rst_in_ready", bus.in_ready, 1'b1);
    check1("rst_flag_z", bus.flag_z, 1'b0);
    check1("rst_flag_c", bus.flag_c, 1'b0);
    check1("rst_illegal", bus.illegal_op, 1'b0);

    // 1: ADD 5+7, one-cycle latency
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    issue(OP_ADD, 32'd12, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, w);
    check1("t1_out_valid", bus.out_valid, 1'b1);
    check32("t1_out_result", bus.out_result, 32'd12);
    check1("t1_flag_z", bus.flag_z, 1'b0);
    check1("t1_flag_c", bus.flag_c, 1'b0);
    idle();

    // 2: SUB 3-3 sets Z; SHL leaves Z, updates C; AND leaves C
    issue(OP_SUB, 32'd0, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, w);
    check1("t2_sub_z", bus.flag_z, 1'b1);
    check1("t2_sub_c", bus.flag_c, 1'b1);
    issue(OP_SHL, 32'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, w);
    check1("t2_shl_z", bus.flag_z, 1'b1);
    check1("t2_shl_c", bus.flag_c, 1'b0);
    issue(OP_AND, 32'h5, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, w);
    check1("t2_and_z", bus.flag_z, 1'b0);
    check1("t2_and_c", bus.flag_c, 1'b0);
    idle();
    repeat (2) @(posedge clk);
    #1;

    // 3: back-pressure, three back-to-back ops
    bus.out_ready = 1'b0;
    issue(OP_AND, 32'hF0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, w);
    issue(OP_OR, 32'hFF, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, w);
    check32("t3_second_wait", 32'(w), 32'd0);
    check1("t3_in_ready_low", bus.in_ready, 1'b0);
    bus.in_opcode = OP_XOR; bus.alu_result = 32'h0F; bus.in_rd = 5'd7;
    repeat (2) begin
      @(negedge clk);
      check1("t3_stall_ready", bus.in_ready, 1'b0);
      check1("t3_stall_valid", bus.out_valid, 1'b1);
      check32("t3_stall_result", bus.out_result, 32'hF0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    issue(OP_XOR, 32'h0F, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, w);
    check32("t3_third_wait", 32'(w), 32'd1);
    idle();
    repeat (3) @(posedge clk);
    #1;

    // 4: illegal opcodes, clear vs set priority
    issue(4'hC, 32'hDEAD, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, w);
    check1("t4_illegal_set", bus.illegal_op, 1'b1);
    check1("t4_z_hold", bus.flag_z, 1'b0);
    check1("t4_c_hold", bus.flag_c, 1'b0);
    check1("t4_wr_en", bus.out_wr_en, 1'b0);
    check32("t4_result", bus.out_result, 32'h0);
    issue(4'hF, 32'hBEEF, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, w);
    check1("t4_set_wins", bus.illegal_op, 1'b1);
    issue(OP_MUL, 32'd42, 1'b0, 1'b1, 5'd10, 1'b1, 1'b1, w);
    check1("t4_cleared", bus.illegal_op, 1'b0);
    idle();
    repeat (2) @(posedge clk);
    #1;

    // 5: streaming, one result per cycle
    pops0 = n_pop;
    for (int i = 0; i < 16; i++) begin
      issue(OP_ADD, 32'(i * 3 + 1), 1'b0, i[0], 5'(i + 11), 1'b1, 1'b0, w);
      check32("t5_no_stall", 32'(w), 32'd0);
    end
    idle();
    repeat (2) @(posedge clk);
    #1;
    check32("t5_pop_count", 32'(n_pop - pops0), 32'd16);

    // 6: reset with skid full discards both entries
    bus.out_ready = 1'b0;
    issue(OP_SUB, 32'd0, 1'b1, 1'b1, 5'd20, 1'b1, 1'b0, w);
    issue(OP_ADD, 32'd99, 1'b0, 1'b1, 5'd21, 1'b1, 1'b0, w);
    idle();
    @(negedge clk);
    check1("t6_skid_full", bus.in_ready, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    m_z = 1'b0; m_c = 1'b0; m_ill = 1'b0;
    check1("t6_out_valid", bus.out_valid, 1'b0);
    check1("t6_in_ready", bus.in_ready, 1'b1);
    check1("t6_flag_z", bus.flag_z, 1'b0);
    check1("t6_flag_c", bus.flag_c, 1'b0);
    bus.out_ready = 1'b1;
    issue(OP_OR, 32'h1234, 1'b0, 1'b0, 5'd22, 1'b1, 1'b0, w);
    idle();

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check32("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
